// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm -- main control sequencer for the multi-cycle CPU datapath.
//
// Steps one instruction through fetch, decode, execute, memory and write-back.
// Each step is one state. The FSM drives every datapath select and write
// enable. It stalls memory states on mem_ready. It traps to ERR on an illegal
// opcode/funct, or when a memory state waits WAIT_LIMIT cycles without
// mem_ready.
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   opcode, funct IR[31:26] / IR[5:0]
//   zero          ALU zero flag (branch condition)
//   mem_ready     memory completes the current read/write this cycle
//   pc_en         PC write enable (branch condition folded in)
//   iord          memory address source: 0 PC, 1 ALUOut
//   mem_read/mem_write  memory requests
//   ir_write, reg_write register enables
//   reg_dst       00 rt, 01 rd, 10 r31
//   mem_to_reg    00 ALUOut, 01 MDR, 10 PC
//   alu_src_a     0 PC, 1 reg A
//   alu_src_b     00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//   alu_ctrl      000 and, 001 or, 010 add, 110 sub, 111 slt
//   pc_source     00 ALU result, 01 ALUOut, 10 jump target
//   state         current state code (debug)
//   err           00 none, 01 illegal instruction, 10 memory timeout
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic [1:0] err
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
    S_WBL = 4'd4,  S_MWR = 4'd5,  S_EXR = 4'd6,  S_WBR = 4'd7,
    S_BR  = 4'd8,  S_JMP = 4'd9,  S_JAL = 4'd10, S_EXI = 4'd11,
    S_WBI = 4'd12, S_ERR = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // The wait counter holds the number of wait cycles already spent. A timeout
  // fires on the cycle that would bring it up to WAIT_LIMIT.
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic [1:0] err_d;
  logic       is_sw, is_bne;
  logic       mem_state, timeout;
  logic       funct_ok;
  logic [2:0] funct_alu;

  assign state = state_q;

  // funct decode for R-type instructions.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign mem_state = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == LIMIT_M1);

  // Next state and error code.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    err_d   = err;
    case (state_q)
      S_IF: begin
        if (mem_ready)    state_d = S_ID;
        else if (timeout) begin state_d = S_ERR; err_d = ERR_TIMEOUT; end
      end
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MA;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:           state_d = S_JMP;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI:        state_d = S_EXI;
          OP_R: begin
            if (funct_ok) state_d = S_EXR;
            else begin state_d = S_ERR; err_d = ERR_ILLEGAL; end
          end
          default: begin state_d = S_ERR; err_d = ERR_ILLEGAL; end
        endcase
      end
      S_MA:  state_d = is_sw ? S_MWR : S_MRD;
      S_MRD: begin
        if (mem_ready)    state_d = S_WBL;
        else if (timeout) begin state_d = S_ERR; err_d = ERR_TIMEOUT; end
      end
      S_MWR: begin
        if (mem_ready)    state_d = S_IF;
        else if (timeout) begin state_d = S_ERR; err_d = ERR_TIMEOUT; end
      end
      S_EXR: state_d = S_WBR;
      S_EXI: state_d = S_WBI;
      S_WBL, S_WBR, S_WBI, S_BR, S_JMP, S_JAL: state_d = S_IF;
      S_ERR: state_d = S_ERR;
      default: state_d = S_IF;
    endcase
  end

  // Moore outputs from state. pc_en and ir_write in IF and pc_en in BR
  // also look at mem_ready/zero in the same cycle. Reset forces all to 0.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_AND;
    pc_source  = 2'b00;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_ID: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
        end
        S_MA: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        S_MRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_WBL: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXR: begin
          alu_src_a = 1'b1;
          alu_ctrl  = funct_alu;
        end
        S_WBR: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          alu_ctrl  = funct_alu;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_source = 2'b01;
          pc_en     = is_bne ? ~zero : zero;
        end
        S_JMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
        end
        S_JAL: begin
          pc_source  = 2'b10;
          pc_en      = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        S_EXI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        S_WBI: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  // State, error, wait counter and decode flags. The opcode is only valid in
  // ID, so the lw/sw and beq/bne choices are latched there for MA and BR.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IF;
      wait_cnt <= 8'd0;
      err      <= ERR_NONE;
      is_sw    <= 1'b0;
      is_bne   <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= err_d;
      if (state_q == S_ID) begin
        is_sw  <= (opcode == OP_SW);
        is_bne <= (opcode == OP_BNE);
      end
      if ((state_d != state_q) || mem_ready || !mem_state) wait_cnt <= 8'd0;
      else                                                 wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule
